mem_sweep_ctrl: RTL and testbench

//  Sequencer for one simple-dual-port block RAM (1-cycle registered read, one write port).
//  On command it fills every address with a generated pattern (FILL), or reads every address

---
 rtl/mem_sweep_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_sweep_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sweep_ctrl.sv
// Fill/check sequencer for a simple-dual-port block RAM with a 1-cycle registered read.
// FILL writes a seed-derived pattern to every word; CHECK reads it back and tallies mismatches.
module mem_sweep_ctrl #(
    parameter int WID_MEM   = 9,
    parameter int DEPTH_MEM = 8192,
    parameter int ADDR_W    = 13
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic               pat_sel,
    input  logic [WID_MEM-1:0] seed,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [ADDR_W:0]    err_count,
    output logic               err_seen,
    output logic [ADDR_W-1:0]  first_err_addr,
    output logic [ADDR_W-1:0]  mem_raddr,
    output logic [ADDR_W-1:0]  mem_waddr,
    output logic [WID_MEM-1:0] mem_din,
    output logic               mem_we,
    input  logic [WID_MEM-1:0] mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH_MEM - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W:0]     addr_reg;
    logic                pat_sel_reg;
    logic [WID_MEM-1:0]  seed_reg;
    logic [ADDR_W-1:0]   cmp_addr_reg;
    logic                cmp_vld_reg;
    logic [ADDR_W:0]     err_count_reg;
    logic                err_seen_reg;
    logic [ADDR_W-1:0]   first_err_reg;
    logic [ADDR_W-1:0]   raddr_hold_reg;
    logic [ADDR_W-1:0]   waddr_hold_reg;
    logic                aborted_reg;

    logic                sweeping;
    logic                abort_now;
    logic                start_accept;
    logic                at_last;
    logic                mismatch;

    // The size cast zero-extends or truncates the address to the data width.
    function automatic logic [WID_MEM-1:0] pattern(input logic ps, input logic [WID_MEM-1:0] sd,
                                                   input logic [ADDR_W:0] a);
        return ps ? WID_MEM'(a) + sd : sd;
    endfunction

    assign sweeping     = (state_reg == S_FILL) || (state_reg == S_READ) || (state_reg == S_DRAIN);
    assign abort_now    = abort && sweeping;
    assign start_accept = (state_reg == S_IDLE) && start;
    assign at_last      = (addr_reg == LAST_ADDR);
    // An abort in the same cycle discards the pending compare.
    assign mismatch     = cmp_vld_reg && !abort_now &&
                          (mem_dout != pattern(pat_sel_reg, seed_reg, {1'b0, cmp_addr_reg}));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = mode ? S_READ : S_FILL;
            S_FILL:  if (abort) state_next = S_IDLE;
                     else if (at_last) state_next = S_DONE;
            S_READ:  if (abort) state_next = S_IDLE;
                     else if (at_last) state_next = S_DRAIN;
            S_DRAIN: state_next = abort ? S_IDLE : S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy           = sweeping;
        done           = (state_reg == S_DONE);
        aborted        = aborted_reg;
        err_count      = err_count_reg;
        err_seen       = err_seen_reg;
        first_err_addr = first_err_reg;
        mem_we         = (state_reg == S_FILL);
        mem_din        = '0;
        mem_waddr      = waddr_hold_reg;
        mem_raddr      = raddr_hold_reg;
        if (state_reg == S_FILL) begin
            mem_din   = pattern(pat_sel_reg, seed_reg, addr_reg);
            mem_waddr = addr_reg[ADDR_W-1:0];
        end
        if (state_reg == S_READ) begin
            mem_raddr = addr_reg[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            addr_reg       <= '0;
            pat_sel_reg    <= 1'b0;
            seed_reg       <= '0;
            cmp_addr_reg   <= '0;
            cmp_vld_reg    <= 1'b0;
            err_count_reg  <= '0;
            err_seen_reg   <= 1'b0;
            first_err_reg  <= '0;
            raddr_hold_reg <= '0;
            waddr_hold_reg <= '0;
            aborted_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            aborted_reg <= abort_now;
            cmp_vld_reg <= (state_reg == S_READ) && !abort;

            if (start_accept) begin
                pat_sel_reg <= pat_sel;
                seed_reg    <= seed;
                addr_reg    <= '0;
            end else if (((state_reg == S_FILL) || (state_reg == S_READ)) && !at_last) begin
                addr_reg <= addr_reg + 1'b1;
            end

            if (state_reg == S_FILL) waddr_hold_reg <= addr_reg[ADDR_W-1:0];
            if (state_reg == S_READ) begin
                raddr_hold_reg <= addr_reg[ADDR_W-1:0];
                cmp_addr_reg   <= addr_reg[ADDR_W-1:0];
            end

            if (start_accept) begin
                err_count_reg <= '0;
                err_seen_reg  <= 1'b0;
                first_err_reg <= '0;
            end else if (mismatch) begin
                if (err_count_reg != '1) err_count_reg <= err_count_reg + 1'b1;
                if (!err_seen_reg) begin
                    err_seen_reg  <= 1'b1;
                    first_err_reg <= cmp_addr_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Scoreboard bench for mem_sweep_ctrl: a behavioural RAM plus a reference image of its contents
// predicts each sweep's outcome; a negedge monitor checks every done/aborted event against it.
module tb_mem_sweep_ctrl;
    localparam int W  = 9;
    localparam int D  = 8192;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0, mode = 1'b0, pat_sel = 1'b0, abort = 1'b0;
    logic [W-1:0]  seed = '0;
    logic          busy, done, aborted, err_seen, mem_we;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_err_addr, mem_raddr, mem_waddr;
    logic [W-1:0]  mem_din, mem_dout;

    mem_sweep_ctrl #(.WID_MEM(W), .DEPTH_MEM(D), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .pat_sel(pat_sel), .seed(seed),
        .abort(abort), .busy(busy), .done(done), .aborted(aborted), .err_count(err_count),
        .err_seen(err_seen), .first_err_addr(first_err_addr), .mem_raddr(mem_raddr),
        .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM with a backdoor write port used only while the DUT is idle.
    logic [W-1:0]  ram [0:D-1];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [W-1:0]  bd_data = '0;
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_we) ram[mem_waddr] <= mem_din;
        mem_dout <= ram[mem_raddr];
    end

    int ref_mem [D];
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit is_abort;
        int at_cyc;
        int cnt;
        bit seen;
        int first;
    } exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0, we_count = 0, last_cnt = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int pat(input bit ps, input int sd, input int a);
        return ps ? (a + sd) % (1 << W) : sd;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mem_we) we_count++;
        if (done || aborted) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: done=%0d aborted=%0d with nothing expected", done, aborted);
            end else begin
                e = sb.pop_front();
                $display("txn %s cyc=%0d err_count=%0d err_seen=%0d first_err_addr=%0d",
                         aborted ? "aborted" : "done", cyc, err_count, err_seen, first_err_addr);
                chk("event_is_abort", int'(aborted), int'(e.is_abort));
                chk("event_cycle", cyc, e.at_cyc);
                chk("err_count", int'(err_count), e.cnt);
                chk("err_seen", int'(err_seen), int'(e.seen));
                chk("first_err_addr", int'(first_err_addr), e.first);
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_aborted"}, int'(aborted), 0);
        chk({tag, "_err_count"}, int'(err_count), 0);
        chk({tag, "_err_seen"}, int'(err_seen), 0);
        chk({tag, "_first_err_addr"}, int'(first_err_addr), 0);
        chk({tag, "_mem_raddr"}, int'(mem_raddr), 0);
        chk({tag, "_mem_waddr"}, int'(mem_waddr), 0);
        chk({tag, "_mem_din"}, int'(mem_din), 0);
        chk({tag, "_mem_we"}, int'(mem_we), 0);
    endtask

    // Issues a sweep from idle and queues its predicted outcome; abort_off >= 0 aborts a CHECK
    // during the cycle that lies abort_off cycles after the start cycle.
    task automatic launch(input bit m, input bit ps, input int sd, input int abort_off);
        exp_t e;
        int s, ncmp;
        s = cyc;
        ncmp = D;
        if (abort_off >= 0) ncmp = (abort_off - 2 < D) ? abort_off - 2 : D;
        if (ncmp < 0) ncmp = 0;
        e.is_abort = (abort_off >= 0);
        e.at_cyc   = (abort_off >= 0) ? s + abort_off + 1 : s + D + 1 + int'(m);
        e.cnt = 0; e.seen = 0; e.first = 0;
        if (!m) begin
            for (int a = 0; a < D; a++) ref_mem[a] = pat(ps, sd, a);
        end else begin
            for (int k = 0; k < ncmp; k++) begin
                if (ref_mem[k] != pat(ps, sd, k)) begin
                    if (!e.seen) e.first = k;
                    e.seen = 1;
                    e.cnt++;
                end
            end
        end
        last_cnt = e.cnt;
        sb.push_back(e);
        start = 1'b1; mode = m; pat_sel = ps; seed = W'(sd);
        @(negedge clk);
        start = 1'b0; mode = 1'($urandom); pat_sel = 1'($urandom); seed = W'($urandom);
        chk("busy_after_start", int'(busy), 1);
        if (abort_off >= 0) begin
            repeat (abort_off - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("busy_after_abort", int'(busy), 0);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < D + 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout: %0d events still outstanding", sb.size());
            sb.delete();
        end
        @(negedge clk);
        chk("busy_idle", int'(busy), 0);
    endtask

    task automatic readback();
        int bad = 0;
        for (int a = 0; a < D; a++) if (ram[a] !== W'(ref_mem[a])) bad++;
        chk("readback_mismatches", bad, 0);
    endtask

    task automatic backdoor(input int a, input int v);
        bd_we = 1'b1; bd_addr = AW'(a); bd_data = W'(v);
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[a] = v;
    endtask

    initial begin
        int s, ps, sd, n;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // FILL address+0, then CHECK it back clean
        launch(0, 1, 0, -1); wait_drain(); readback();
        chk("waddr_hold", int'(mem_waddr), D - 1);
        chk("din_idle", int'(mem_din), 0);
        chk("we_idle", int'(mem_we), 0);
        launch(1, 1, 0, -1); wait_drain();
        chk("raddr_hold", int'(mem_raddr), D - 1);

        // Two planted corruptions
        backdoor(100, 'h1FF); backdoor(5000, 0);
        launch(1, 1, 0, -1); wait_drain();

        // Constant fill, check with the wrong seed: every word fails
        launch(0, 0, 'h0AA, -1); wait_drain(); readback();
        launch(1, 0, 'h055, -1); wait_drain();

        // Abort early in CHECK; results must then stay frozen
        abort = 1'b0;
        launch(1, 1, 0, 50); wait_drain();
        repeat (5) @(negedge clk);
        chk("err_count_frozen", int'(err_count), last_cnt);
        // Abort in DRAIN discards the final compare
        launch(1, 0, 'h055, D + 1); wait_drain();
        // Abort and start together in IDLE: start wins
        abort = 1'b1;
        launch(1, 0, 'h0AA, -1);
        abort = 1'b0;
        wait_drain();

        // Stray start during FILL is ignored; count writes
        we_count = 0;
        sd = int'($urandom_range(511, 0));
        s = cyc;
        launch(0, 1, sd, -1);
        while (cyc < s + 10) @(negedge clk);
        start = 1'b1; mode = 1'b1; seed = W'(sd ^ 'h1FF);
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        chk("fill_write_count", we_count, D);
        readback();

        // Random corruption against a random check pattern
        ps = int'($urandom_range(1, 0));
        sd = int'($urandom_range(511, 0));
        n = int'($urandom_range(6, 1));
        for (int i = 0; i < n; i++) backdoor(int'($urandom_range(D - 1, 0)), int'($urandom_range(511, 0)));
        launch(1, bit'(ps), ($urandom_range(1, 0) != 0) ? sd : int'($urandom_range(511, 0)), -1);
        wait_drain();

        // Asynchronous reset in the middle of a FILL, then a full FILL
        sd = int'($urandom_range(511, 0));
        s = cyc;
        launch(0, 0, sd, -1);
        while (cyc < s + 3000) @(negedge clk);
        #2 reset = 1'b1;
        sb.delete();
        #1 check_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        launch(0, 1, sd, -1); wait_drain(); readback();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
